// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master in front of the timer register block.
// Optional build macro: APB_TIMEOUT_EN -- bounds the ACCESS phase to TIMEOUT_CYC cycles
// and completes a stalled transfer with resp_err=1 and resp_rdata=0.
module apb_master_arbiter #(
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned ADDR_SIZE   = 32,
    parameter int unsigned PSTRB_SIZE  = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                    pclk,
    input  logic                    prst_n,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_SIZE-1:0]  req_addr,
    input  logic [2*DATA_SIZE-1:0]  req_wdata,
    input  logic [2*PSTRB_SIZE-1:0] req_strb,
    output logic [1:0]              resp_valid,
    output logic [DATA_SIZE-1:0]    resp_rdata,
    output logic                    resp_err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_SIZE-1:0]    paddr,
    output logic [DATA_SIZE-1:0]    pwdata,
    output logic [PSTRB_SIZE-1:0]   pstrb,
    input  logic [DATA_SIZE-1:0]    prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                  state_q, state_d;
    logic                    ptr_q, ptr_d;       // last granted requester
    logic                    grant_q, grant_d;   // owner of the transfer in flight
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_SIZE-1:0]    paddr_q, paddr_d;
    logic [DATA_SIZE-1:0]    pwdata_q, pwdata_d;
    logic [PSTRB_SIZE-1:0]   pstrb_q, pstrb_d;
    logic [1:0]              resp_valid_q, resp_valid_d;
    logic [DATA_SIZE-1:0]    resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;
    logic                    win;
    logic                    timeout;

    // Round-robin winner: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        win = req_valid[1];
        if (req_valid == 2'b11) begin
            win = ~ptr_q;
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    // Stall cycle that would bring the count to TIMEOUT_CYC ends the transfer; pready wins
    assign timeout = (state_q == StAccess) && !pready && (tmo_cnt_q == TmoLast);

    // ACCESS stall counter, cleared while in SETUP
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == StSetup) begin
            tmo_cnt_d = 8'd0;
        end else if (state_q == StAccess && !pready) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic [7:0] unused_timeout_cyc;

    assign timeout            = 1'b0;
    assign unused_timeout_cyc = 8'(TIMEOUT_CYC);
`endif

    // State register
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SETUP -> ACCESS (wait on pready) -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (|req_valid) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (pready || timeout) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Next values of the registered APB and response outputs
    always_comb begin
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        resp_valid_d = 2'b00;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    ptr_d    = win;
                    grant_d  = win;
                    psel_d   = 1'b1;
                    pwrite_d = req_write[win];
                    paddr_d  = win ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE]
                                   : req_addr[ADDR_SIZE-1:0];
                    pwdata_d = win ? req_wdata[2*DATA_SIZE-1:DATA_SIZE]
                                   : req_wdata[DATA_SIZE-1:0];
                    if (req_write[win]) begin
                        pstrb_d = win ? req_strb[2*PSTRB_SIZE-1:PSTRB_SIZE]
                                      : req_strb[PSTRB_SIZE-1:0];
                    end else begin
                        pstrb_d = '0;
                    end
                end
            end
            StSetup: begin
                penable_d = 1'b1;
            end
            StAccess: begin
                if (pready) begin
                    psel_d                = 1'b0;
                    penable_d             = 1'b0;
                    resp_valid_d[grant_q] = 1'b1;
                    resp_rdata_d          = pwrite_q ? '0 : prdata;
                    resp_err_d            = pslverr;
                end else if (timeout) begin
                    psel_d                = 1'b0;
                    penable_d             = 1'b0;
                    resp_valid_d[grant_q] = 1'b1;
                    resp_rdata_d          = '0;
                    resp_err_d            = 1'b1;
                end
            end
            StResp: begin
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers; reset aborts any transfer in flight
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            ptr_q        <= 1'b1;
            grant_q      <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            resp_valid_q <= 2'b00;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign pstrb      = pstrb_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a response scoreboard and a simple APB slave.
// Build with APB_TIMEOUT_EN defined to exercise the ACCESS timeout path.
module tb_apb_master_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 4;

    logic            pclk       = 1'b0;
    logic            prst_n     = 1'b0;
    logic [1:0]      req_valid  = 2'b00;
    logic [1:0]      req_write  = 2'b00;
    logic [2*AW-1:0] req_addr   = '0;
    logic [2*DW-1:0] req_wdata  = '0;
    logic [2*SW-1:0] req_strb   = '0;
    logic [1:0]      resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic            resp_err;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [SW-1:0]   pstrb;
    logic [DW-1:0]   prdata     = '0;
    logic            pready     = 1'b0;
    logic            pslverr    = 1'b0;

    apb_master_arbiter #(
        .DATA_SIZE   (DW),
        .ADDR_SIZE   (AW),
        .PSTRB_SIZE  (SW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .pclk       (pclk),
        .prst_n     (prst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_strb   (req_strb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    always #5 pclk = ~pclk;

    // Slave: ready after slave_wait stalled ACCESS cycles; drives noise (pready=pslverr=1)
    // outside ACCESS, which the master must ignore.
    int            slave_wait  = 0;
    logic [DW-1:0] slave_rdata = 32'h1234_5678;
    logic          slave_err   = 1'b0;
    int            acc_n       = 0;

    always @(negedge pclk) begin
        if (psel && penable) begin
            acc_n   = acc_n + 1;
            pready  = (acc_n > slave_wait);
            pslverr = slave_err && (acc_n > slave_wait);
            prdata  = slave_rdata;
        end else begin
            acc_n   = 0;
            pready  = 1'b1;
            pslverr = 1'b1;
            prdata  = 32'hDEAD_BEEF;
        end
    end

    typedef struct packed {
        logic [1:0]    who;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
        req_write[i]           = wr;
        req_addr[i*AW +: AW]   = addr;
        req_wdata[i*DW +: DW]  = wdata;
        req_strb[i*SW +: SW]   = strb;
        req_valid[i]           = 1'b1;
    endtask

    task automatic push(input logic [1:0] who, input logic [DW-1:0] rdata, input logic err);
        exp_t e;
        e.who   = who;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a completion pulse and compare it with the oldest expectation
    task automatic wait_resp(input string tag, input int max_cyc);
        int   n = 0;
        exp_t e;
        while (resp_valid == 2'b00 && n < max_cyc) begin
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            check({tag, " unexpected_resp"}, 64'(resp_valid), 64'd0);
        end else begin
            e = sb.pop_front();
            check({tag, " resp_valid"}, 64'(resp_valid), 64'(e.who));
            check({tag, " resp_rdata"}, 64'(resp_rdata), 64'(e.rdata));
            check({tag, " resp_err"}, 64'(resp_err), 64'(e.err));
        end
    endtask

    initial begin
        int   n;
        logic hold_ok;

        // Reset values
        tick();
        check("rst psel", 64'(psel), 64'd0);
        check("rst penable", 64'(penable), 64'd0);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst resp_err", 64'(resp_err), 64'd0);
        check("rst paddr", 64'(paddr), 64'd0);
        check("rst pwdata", 64'(pwdata), 64'd0);
        check("rst pstrb", 64'(pstrb), 64'd0);
        check("rst pwrite", 64'(pwrite), 64'd0);
        prst_n = 1'b1;
        tick();
        check("idle psel", 64'(psel), 64'd0);

        // 1: req0 write, ready on the 2nd ACCESS cycle
        set_req(0, 1'b1, 32'h0000_0004, 32'hA5A5_0001, 4'hF);
        slave_wait = 1;
        push(2'b01, 32'h0, 1'b0);
        tick();
        check("t1 setup psel", 64'(psel), 64'd1);
        check("t1 setup penable", 64'(penable), 64'd0);
        check("t1 paddr", 64'(paddr), 64'h4);
        check("t1 pwdata", 64'(pwdata), 64'hA5A5_0001);
        check("t1 pstrb", 64'(pstrb), 64'hF);
        check("t1 pwrite", 64'(pwrite), 64'd1);
        tick();
        check("t1 acc1 penable", 64'(penable), 64'd1);
        check("t1 acc1 resp_valid", 64'(resp_valid), 64'd0);
        tick();
        check("t1 acc2 psel", 64'(psel), 64'd1);
        check("t1 acc2 penable", 64'(penable), 64'd1);
        check("t1 acc2 paddr", 64'(paddr), 64'h4);
        tick();
        wait_resp("t1", 0);
        check("t1 resp psel", 64'(psel), 64'd0);
        req_valid[0] = 1'b0;
        tick();

        // 2: req1 read, ready on the 1st ACCESS cycle, strobes forced to 0
        set_req(1, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 4'hC);
        slave_wait  = 0;
        slave_rdata = 32'h1234_5678;
        push(2'b10, 32'h1234_5678, 1'b0);
        tick();
        check("t2 setup psel", 64'(psel), 64'd1);
        check("t2 pwrite", 64'(pwrite), 64'd0);
        check("t2 pstrb", 64'(pstrb), 64'd0);
        check("t2 paddr", 64'(paddr), 64'h10);
        tick();
        check("t2 acc penable", 64'(penable), 64'd1);
        tick();
        wait_resp("t2", 0);
        req_valid[1] = 1'b0;
        tick();

        // 3: both valid from reset -> grants 0,1,0,1 with an IDLE gap each time
        prst_n = 1'b0;
        tick();
        check("t3 rst psel", 64'(psel), 64'd0);
        prst_n = 1'b1;
        set_req(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h0000_0030, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            push((k % 2 == 0) ? 2'b01 : 2'b10, 32'h1234_5678, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            wait_resp("t3", 8);
            if (k == 3) begin
                req_valid = 2'b00;
            end
            tick();
            check("t3 idle gap psel", 64'(psel), 64'd0);
        end

        // 4: slave error on a read, then a clean write
        set_req(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
        slave_err = 1'b1;
        push(2'b01, 32'h1234_5678, 1'b1);
        wait_resp("t4a", 8);
        req_valid = 2'b00;
        slave_err = 1'b0;
        tick();
        set_req(1, 1'b1, 32'h0000_0044, 32'h0000_0055, 4'h3);
        push(2'b10, 32'h0, 1'b0);
        wait_resp("t4b", 8);
        req_valid = 2'b00;
        tick();

        // 5: slave never ready
        slave_wait  = 1000;
        slave_rdata = 32'hCAFE_F00D;
        set_req(0, 1'b0, 32'h0000_0050, 32'h0, 4'hF);
        tick();
        check("t5 setup psel", 64'(psel), 64'd1);
        tick();
`ifdef APB_TIMEOUT_EN
        push(2'b01, 32'h0, 1'b1);
        n = 0;
        while (psel && penable && n < 200) begin
            n++;
            tick();
        end
        check("t5 access_cycles", 64'(n), 64'(TMO));
        wait_resp("t5", 0);
`else
        hold_ok = 1'b1;
        for (int k = 0; k < 110; k++) begin
            if (!(psel && penable)) begin
                hold_ok = 1'b0;
            end
            tick();
        end
        check("t5 psel_held", 64'(hold_ok), 64'd1);
        push(2'b01, 32'hCAFE_F00D, 1'b0);
        slave_wait = 0;
        wait_resp("t5", 5);
`endif
        req_valid = 2'b00;
        tick();

        // 6: reset during ACCESS aborts; held req1 is granted after release
        slave_wait  = 1000;
        slave_rdata = 32'h1234_5678;
        set_req(1, 1'b0, 32'h0000_0060, 32'h0, 4'hF);
        tick();
        tick();
        check("t6 acc penable", 64'(penable), 64'd1);
        prst_n = 1'b0;
        #1;
        check("t6 abort psel", 64'(psel), 64'd0);
        check("t6 abort penable", 64'(penable), 64'd0);
        check("t6 abort resp_valid", 64'(resp_valid), 64'd0);
        slave_wait = 0;
        tick();
        prst_n = 1'b1;
        tick();
        check("t6 regrant psel", 64'(psel), 64'd1);
        check("t6 regrant penable", 64'(penable), 64'd0);
        check("t6 regrant paddr", 64'(paddr), 64'h60);
        push(2'b10, 32'h1234_5678, 1'b0);
        wait_resp("t6", 5);
        req_valid = 2'b00;
        tick();
        check("sb empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
